mem_1r1w_masked_banked: RTL and testbench
=========================================

Name: mem_1r1w_masked_banked

Overview:
- Parametrised single-clock 1R1W memory with byte-granular write mask.
- Built from BANKS unmasked sync-read macro banks. Each bank has read port A and write port B, MACRO_DEPTH words deep.
- Partial-mask writes are emulated by a 2-cycle read-modify-write (RMW).
- Successor to the fixed 32x64 masked wrapper. Adds depth banking, ready/valid handshake, RMW masking and read-after-write bypass.

Parameters:
- DEPTH, 128, total words; power of two, multiple of MACRO_DEPTH.
- WIDTH, 64, data bits; multiple of MASK_GRAN.
- MASK_GRAN, 8, bits per mask lane.
- MACRO_DEPTH, 32, words per bank macro; power of two.
- Derived constants: AW=clog2(DEPTH), MW=WIDTH/MASK_GRAN, BANKS=DEPTH/MACRO_DEPTH.

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- R0_addr  in  AW  read address
- R0_en  in  1  read request
- R0_ready  out  1  read accepted this cycle when R0_en&&R0_ready
- R0_valid  out  1  R0_data holds result of the last accepted read
- R0_data  out  WIDTH  read data
- W0_addr  in  AW  write address
- W0_en  in  1  write request
- W0_ready  out  1  write accepted this cycle when W0_en&&W0_ready
- W0_data  in  WIDTH  write data
- W0_mask  in  MW  lane enables; bit i covers W0_data[i*MASK_GRAN +: MASK_GRAN]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n).
- Reset values:
  - R0_valid=0, R0_data=0.
  - FSM=IDLE.
  - W0_ready=1 after reset, or 0 while INIT when MEM_INIT_ZERO_EN is defined.
  - Array contents are not reset.
- Banking:
  - bank = addr[AW-1:log2(MACRO_DEPTH)]; row = low bits.
  - Only the addressed bank's port is enabled.
- Write classes at acceptance:
  - Full: mask all ones. Written to port B in the acceptance cycle.
  - Empty: mask zero. Accepted, no array access.
  - Partial: any other mask. Enters RMW.
- FSM IDLE -> MERGE on an accepted partial write:
  - The acceptance cycle issues a port-A read of W0_addr.
  - Addr, data and mask are latched.
- FSM MERGE:
  - merged = (old & ~expand(mask)) | (data & expand(mask)).
  - merged is written on port B; FSM returns to IDLE next cycle.
  - W0_ready=0 in MERGE. Partial-write throughput is 1 per 2 cycles; full writes run 1 per cycle.
- Port A arbitration:
  - R0_ready = !(FSM==IDLE && W0_en && W0_ready && partial).
  - The RMW read wins over the user read.
  - R0_ready=1 in MERGE.
- Read latency:
  - Accepted at cycle t: R0_data is valid at t+1 with R0_valid=1.
  - R0_data and R0_valid hold until the next accepted read; R0_valid stays 1 after the first read.
  - R0_en=0 does not clear R0_valid.
- Ordering: a read accepted at cycle t returns data including every write accepted before t.
  - Same-cycle write is read-first: the old value is returned.
- MERGE bypass: a read accepted in MERGE to the latched address returns merged, not stale macro data.
- Simultaneous accepted read and full write, same address: read returns the old word.
- Reset mid-RMW:
  - FSM is forced to IDLE and the pending merge is discarded.
  - The word keeps its pre-write value.
  - Outputs take their reset values.

Optional Feature:
- Macro: MEM_INIT_ZERO_EN.
- Defined:
  - After reset_n rises, state INIT sweeps rows 0..MACRO_DEPTH-1, writing zero to all banks in parallel, one row per cycle.
  - W0_ready=0 and R0_ready=0 during INIT.
  - Enters IDLE after MACRO_DEPTH cycles.
  - Reset during INIT restarts the sweep.
- Not defined: no INIT state; ready signals follow the normal rules immediately after reset and contents are undefined.

Test Plan:
- Full write then read:
  - Write addr 0x45 data 0x0123456789ABCDEF, mask 0xFF.
  - Next cycle read 0x45 -> R0_data=0x0123456789ABCDEF one cycle after acceptance, R0_valid=1.
  - Bank 2 only enabled.
- Partial write:
  - Preload 0x10=0xFFFFFFFFFFFFFFFF.
  - Write 0x10 data 0, mask 0x0F -> W0_ready=0 next cycle (MERGE).
  - Later read returns 0xFFFFFFFF00000000.
- Arbitration and bypass:
  - Partial write 0x10 with simultaneous R0_en -> R0_ready=0 that cycle.
  - Read of 0x10 in MERGE -> merged value returned.
- Read-first:
  - Same-cycle full write 0x7F=0xAA.. and read 0x7F holding 0x55.. -> returns 0x55.., then 0xAA.. next read.
- Mask zero and back-to-back: mask 0x00 write -> word unchanged, W0_ready stays 1; four consecutive full writes accepted in four cycles.
- Reset:
  - Assert reset_n=0 during MERGE -> word keeps its old value, R0_valid=0.
  - With MEM_INIT_ZERO_EN: readies low for 32 cycles, then a read of 0x3A returns 0.

Source files
------------

// File: rtl/mem_1r1w_masked_banked.sv
// Banked 1R1W memory with byte-lane write mask, emulated by read-modify-write on partial masks.
// Optional MEM_INIT_ZERO_EN: after reset, sweep every row to zero before accepting traffic.
module mem_1r1w_masked_banked #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned MASK_GRAN   = 8,
  parameter int unsigned MACRO_DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned MW = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic             R0_ready,
  output logic             R0_valid,
  output logic [WIDTH-1:0] R0_data,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  output logic             W0_ready,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [MW-1:0]    W0_mask
);

  localparam int unsigned BANKS = DEPTH / MACRO_DEPTH;
  localparam int unsigned RW    = $clog2(MACRO_DEPTH);
  localparam int unsigned BW    = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef enum logic [1:0] {StIdle, StMerge, StInit} state_e;

`ifdef MEM_INIT_ZERO_EN
  localparam state_e StReset = StInit;
`else
  localparam state_e StReset = StIdle;
`endif

  function automatic logic [BW-1:0] bank_of(logic [AW-1:0] a);
    return BW'(a >> RW);
  endfunction

  function automatic logic [RW-1:0] row_of(logic [AW-1:0] a);
    return a[RW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] expand(logic [MW-1:0] m);
    logic [WIDTH-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < MW; i++) e[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{m[i]}};
    return e;
  endfunction

  state_e           state_q, state_d;
  logic [RW-1:0]    init_row_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q, merged_q, merged;
  logic [MW-1:0]    mask_q;
  logic             r_pend_q, r_byp_q, r_valid_q;
  logic [BW-1:0]    r_bank_q;
  logic [WIDTH-1:0] r_data_q;

  logic             w_full, w_partial, rmw_start, r_acc;
  logic             a_go, b_go, init_all;
  logic [AW-1:0]    a_addr, b_addr;
  logic [RW-1:0]    b_row;
  logic [WIDTH-1:0] b_data;
  logic [BANKS-1:0] a_en, b_en;
  logic [WIDTH-1:0] a_rdata [BANKS];

  assign w_full    = &W0_mask;
  assign w_partial = (|W0_mask) && !w_full;
  assign W0_ready  = (state_q == StIdle);
  assign rmw_start = W0_ready && W0_en && w_partial;
  // The RMW read owns port A in its acceptance cycle.
  assign R0_ready  = (state_q == StMerge) || ((state_q == StIdle) && !(W0_en && w_partial));
  assign r_acc     = R0_en && R0_ready;

  assign a_go   = rmw_start || r_acc;
  assign a_addr = rmw_start ? W0_addr : R0_addr;
  assign merged = (a_rdata[bank_of(addr_q)] & ~expand(mask_q)) | (data_q & expand(mask_q));

  always_comb begin
    b_go     = 1'b0;
    b_addr   = W0_addr;
    b_data   = W0_data;
    init_all = 1'b0;
    unique case (state_q)
      StIdle:  b_go = W0_en && w_full;
      StMerge: begin
        b_go   = 1'b1;
        b_addr = addr_q;
        b_data = merged;
      end
      StInit:  begin
        init_all = 1'b1;
        b_data   = '0;
      end
      default: ;
    endcase
    b_row = init_all ? init_row_q : row_of(b_addr);
  end

  always_comb begin
    a_en = '0;
    b_en = '0;
    for (int unsigned i = 0; i < BANKS; i++) begin
      a_en[i] = a_go && (bank_of(a_addr) == BW'(i));
      b_en[i] = init_all || (b_go && (bank_of(b_addr) == BW'(i)));
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [MACRO_DEPTH];
    logic [WIDTH-1:0] rdata_q;
    // Read-first macro: a same-cycle write is not visible to the read.
    always_ff @(posedge clock) begin
      if (b_en[b]) mem[b_row] <= b_data;
      if (a_en[b]) rdata_q <= mem[row_of(a_addr)];
    end
    assign a_rdata[b] = rdata_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rmw_start) state_d = StMerge;
      StMerge: state_d = StIdle;
      StInit:  if (init_row_q == RW'(MACRO_DEPTH - 1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A read returns fresh macro data (or the merge bypass) for one cycle, then holds.
  assign R0_data  = r_pend_q ? (r_byp_q ? merged_q : a_rdata[r_bank_q]) : r_data_q;
  assign R0_valid = r_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StReset;
      init_row_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      merged_q   <= '0;
      r_pend_q   <= 1'b0;
      r_byp_q    <= 1'b0;
      r_valid_q  <= 1'b0;
      r_bank_q   <= '0;
      r_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StInit) init_row_q <= init_row_q + RW'(1);
      if (rmw_start) begin
        addr_q <= W0_addr;
        data_q <= W0_data;
        mask_q <= W0_mask;
      end
      if (state_q == StMerge) merged_q <= merged;
      r_pend_q <= r_acc;
      r_byp_q  <= r_acc && (state_q == StMerge) && (R0_addr == addr_q);
      if (r_acc) begin
        r_bank_q  <= bank_of(R0_addr);
        r_valid_q <= 1'b1;
      end
      if (r_pend_q) r_data_q <= R0_data;
    end
  end

endmodule

// File: tb/tb_mem_1r1w_masked_banked.sv
// Randomized scoreboard bench for mem_1r1w_masked_banked against a word-level reference array.
// Honours MEM_INIT_ZERO_EN when compiled with it.
module tb_mem_1r1w_masked_banked;
  localparam int DEPTH = 128;
  localparam int WIDTH = 64;
  localparam int MD    = 32;
  localparam int AW    = 7;
  localparam int MW    = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic [AW-1:0]    R0_addr = '0;
  logic             R0_en = 1'b0;
  logic             R0_ready, R0_valid;
  logic [WIDTH-1:0] R0_data;
  logic [AW-1:0]    W0_addr = '0;
  logic             W0_en = 1'b0;
  logic             W0_ready;
  logic [WIDTH-1:0] W0_data = '0;
  logic [MW-1:0]    W0_mask = '0;

  mem_1r1w_masked_banked dut (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_ready(R0_ready), .R0_valid(R0_valid),
    .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_ready(W0_ready), .W0_data(W0_data),
    .W0_mask(W0_mask)
  );

  always #5 clock = ~clock;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] last_exp = '0;
  logic             exp_valid = 1'b0;
  bit               busy = 1'b0;
  int               checks = 0;
  int               errors = 0;

  task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] apply_mask(logic [WIDTH-1:0] old, logic [WIDTH-1:0] d,
                                                  logic [MW-1:0] m);
    logic [WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < MW; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Monitor: a read accepted before an edge presents its word just after that edge.
  initial forever begin
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      exp_valid = 1'b1;
      check("rdata", R0_data, last_exp);
      check("rvalid", {63'd0, R0_valid}, 64'd1);
    end else begin
      check("rdata_hold", R0_data, last_exp);
      check("rvalid_hold", {63'd0, R0_valid}, {63'd0, exp_valid});
    end
  end

  // One cycle of stimulus, issued at a negedge; checks readies and books expectations.
  task automatic cycle(bit re, logic [AW-1:0] ra, bit we, logic [AW-1:0] wa,
                       logic [WIDTH-1:0] wd, logic [MW-1:0] wm);
    bit partial, exp_wr, exp_rr, next_busy;
    R0_en = re; R0_addr = ra; W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
    #1;
    partial = (wm != '0) && (wm != '1);
    exp_wr  = !busy;
    exp_rr  = !(!busy && we && partial);
    check("W0_ready", {63'd0, W0_ready}, {63'd0, exp_wr});
    check("R0_ready", {63'd0, R0_ready}, {63'd0, exp_rr});
    if (re && exp_rr) exp_q.push_back(ref_mem[ra]);
    next_busy = 1'b0;
    if (we && exp_wr) begin
      ref_mem[wa] = apply_mask(ref_mem[wa], wd, wm);
      next_busy = partial;
    end
    busy = next_busy;
    @(negedge clock);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    R0_en = 1'b0; W0_en = 1'b0;
    busy = 1'b0; last_exp = '0; exp_valid = 1'b0;
    exp_q.delete();
    #1;
    check("reset_rvalid", {63'd0, R0_valid}, 64'd0);
    check("reset_rdata", R0_data, '0);
    @(negedge clock);
    reset_n = 1'b1;
`ifdef MEM_INIT_ZERO_EN
    for (int i = 0; i < MD; i++) begin
      #1;
      check("init_wready", {63'd0, W0_ready}, 64'd0);
      check("init_rready", {63'd0, R0_ready}, 64'd0);
      @(negedge clock);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
  endtask

  initial begin
    logic [AW-1:0]    ra, wa;
    logic [WIDTH-1:0] wd;
    logic [MW-1:0]    wm;
    #2;
    @(negedge clock);
    do_reset();
`ifdef MEM_INIT_ZERO_EN
    cycle(1'b1, 7'h3A, 1'b0, '0, '0, '0);
    check("init_zero_model", ref_mem[7'h3A], '0);
`endif
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, '0, 1'b1, AW'(i), {$urandom, $urandom}, '1);

    // Full write then read.
    cycle(1'b0, '0, 1'b1, 7'h45, 64'h0123456789ABCDEF, 8'hFF);
    cycle(1'b1, 7'h45, 1'b0, '0, '0, '0);
    // Partial write with competing read, then bypass read in the merge cycle.
    cycle(1'b0, '0, 1'b1, 7'h10, '1, 8'hFF);
    cycle(1'b1, 7'h10, 1'b1, 7'h10, '0, 8'h0F);
    cycle(1'b1, 7'h10, 1'b1, 7'h11, '1, 8'hFF);
    cycle(1'b1, 7'h10, 1'b0, '0, '0, '0);
    check("partial_model", ref_mem[7'h10], 64'hFFFFFFFF00000000);
    // Read-first on a same-cycle full write.
    cycle(1'b0, '0, 1'b1, 7'h7F, 64'h5555555555555555, 8'hFF);
    cycle(1'b1, 7'h7F, 1'b1, 7'h7F, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    cycle(1'b1, 7'h7F, 1'b0, '0, '0, '0);
    // Empty mask, then back-to-back full writes.
    cycle(1'b0, '0, 1'b1, 7'h20, '1, 8'h00);
    cycle(1'b1, 7'h20, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, AW'(i + 40), {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 4; i++) cycle(1'b1, AW'(i + 40), 1'b0, '0, '0, '0);

    // Random traffic, addresses often drawn from a small hot set to hit bypass paths.
    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3) * 33) : AW'($urandom);
      wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3) * 33) : AW'($urandom);
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: wm = '0;
        1: wm = '1;
        default: wm = MW'($urandom);
      endcase
      cycle(1'($urandom), ra, 1'($urandom), wa, wd, wm);
    end

    // Reset in the merge cycle: the pending write must be dropped.
    cycle(1'b0, '0, 1'b1, 7'h33, 64'h1122334455667788, 8'hFF);
    R0_en = 1'b0; W0_en = 1'b1; W0_addr = 7'h33; W0_data = '0; W0_mask = 8'hF0;
    @(negedge clock);
    W0_en = 1'b0;
    do_reset();
    cycle(1'b1, 7'h33, 1'b0, '0, '0, '0);
    idle();
    idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
